// File: rtl/dds_pulse_sequencer.sv
// Purpose : pulsed-RADAR timing (pulse gate, DDS enable) and debug capture stream control.
// Latency : outputs are registered; a config change takes effect at the next period boundary.
// Backpr. : the debug stream holds tvalid/tlast while tready is low; pulse timing never stalls.
//
// Ports:
//   S_AXI_CLK, S_AXI_ARESETN   clock and async active-low reset (release assumed synchronous upstream)
//   config_reg_0_i             bit0 = enable, bit DEBUG_BIT = debug capture request
//   config_reg_1_i..3_i        period P, width W, pulse count N (0 = continuous)
//   config_reg_4_i             debug sample count D (0 behaves as 1)
//   dbg_tready_i               debug stream consumer ready
//   pulse_o, dds_enable_o      pulse gate and DDS enable
//   cfg_load_o                 1-cycle strobe when the timing shadows load
//   busy_o, pulse_cnt_o        sequence active, pulses started since the last start
//   dbg_tvalid_o, dbg_tlast_o  debug stream handshake outputs
module dds_pulse_sequencer #(
  parameter int CNT_W     = 32,
  parameter int DEBUG_BIT = 1
) (
  input  logic             S_AXI_CLK,
  input  logic             S_AXI_ARESETN,
  input  logic [31:0]      config_reg_0_i,
  input  logic [31:0]      config_reg_1_i,
  input  logic [31:0]      config_reg_2_i,
  input  logic [31:0]      config_reg_3_i,
  input  logic [31:0]      config_reg_4_i,
  input  logic             dbg_tready_i,
  output logic             pulse_o,
  output logic             dds_enable_o,
  output logic             cfg_load_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] pulse_cnt_o,
  output logic             dbg_tvalid_o,
  output logic             dbg_tlast_o
);

  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;
  typedef enum logic [1:0] {DIDLE, DARM, DRUN} dstate_t;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO = CNT_W'(2);

  state_t           r_state;
  dstate_t          r_dstate;
  logic [CNT_W-1:0] r_p;
  logic [CNT_W-1:0] r_w;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] r_pulse_cnt;
  logic             r_pulse;
  logic             r_dds_en;
  logic             r_cfg_load;
  logic             r_busy;
  logic [31:0]      r_dlen;
  logic [31:0]      r_dcnt;
  logic             r_tvalid;
  logic             r_tlast;
  logic             r_dbg_hold;

  logic             w_en;
  logic             w_dbg_req;
  logic [CNT_W-1:0] w_p_raw;
  logic [CNT_W-1:0] w_w_raw;
  logic [CNT_W-1:0] w_p_san;
  logic [CNT_W-1:0] w_w_san;
  logic             w_abort;
  logic             w_on_end;
  logic             w_period_end;
  logic             w_seq_done;
  logic             w_start;
  logic             w_reload;
  logic             w_load;
  logic             w_hs;
  logic             w_unused;

  assign w_en      = config_reg_0_i[0];
  assign w_dbg_req = config_reg_0_i[DEBUG_BIT];

  // Sanitise timing at load: period of at least 2, width strictly below period.
  assign w_p_raw = CNT_W'(config_reg_1_i);
  assign w_w_raw = CNT_W'(config_reg_2_i);
  assign w_p_san = (w_p_raw < C_TWO) ? C_TWO : w_p_raw;
  assign w_w_san = (w_w_raw >= w_p_san) ? (w_p_san - C_ONE) : w_w_raw;

  assign w_abort      = ((r_state == ON) || (r_state == OFF)) && !w_en;
  assign w_on_end     = (r_phase == r_w - C_ONE);
  assign w_period_end = (r_phase == r_p - C_ONE);
  assign w_seq_done   = (r_n != '0) && (r_pulse_cnt == r_n);
  assign w_start      = (r_state == IDLE) && w_en;
  assign w_reload     = (r_state == OFF) && w_en && w_period_end && !w_seq_done;
  assign w_load       = w_start || w_reload;
  assign w_hs         = r_tvalid && dbg_tready_i;

  // Upper config bits are not consumed for narrow CNT_W and bits of reg 0 are partly spare.
  assign w_unused = ^{config_reg_0_i, config_reg_1_i, config_reg_2_i, config_reg_3_i};

  // Pulse timing FSM. Shadows only change on a load, so mid-period writes are invisible.
  always_ff @(posedge S_AXI_CLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state     <= IDLE;
      r_p         <= '0;
      r_w         <= '0;
      r_n         <= '0;
      r_phase     <= '0;
      r_pulse_cnt <= '0;
      r_pulse     <= 1'b0;
      r_dds_en    <= 1'b0;
      r_cfg_load  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cfg_load <= 1'b0;
      if (w_load) begin
        r_p         <= w_p_san;
        r_w         <= w_w_san;
        r_n         <= CNT_W'(config_reg_3_i);
        r_phase     <= '0;
        r_pulse_cnt <= w_start ? C_ONE : (r_pulse_cnt + C_ONE);
        // A zero-width pulse skips ON but still runs the period timing.
        r_state     <= (w_w_san == '0) ? OFF : ON;
        r_pulse     <= (w_w_san != '0);
        r_dds_en    <= 1'b1;
        r_cfg_load  <= 1'b1;
        r_busy      <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_busy <= 1'b0;
          end
          ON, OFF: begin
            if (!w_en) begin
              r_state  <= IDLE;
              r_pulse  <= 1'b0;
              r_dds_en <= 1'b0;
              r_busy   <= 1'b0;
            end else if ((r_state == ON) && w_on_end) begin
              r_state <= OFF;
              r_pulse <= 1'b0;
              r_phase <= r_phase + C_ONE;
            end else if ((r_state == OFF) && w_period_end) begin
              // Only reached when the programmed count is exhausted; reloads take w_load.
              r_state  <= DONE;
              r_pulse  <= 1'b0;
              r_dds_en <= 1'b0;
            end else begin
              r_phase <= r_phase + C_ONE;
            end
          end
          DONE: begin
            if (!w_en) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  // Debug capture FSM. r_dbg_hold blanks one cycle after the final handshake so a
  // request bit not yet cleared by the register bank cannot immediately re-arm.
  always_ff @(posedge S_AXI_CLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_dstate   <= DIDLE;
      r_dlen     <= '0;
      r_dcnt     <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_dbg_hold <= 1'b0;
    end else begin
      r_dbg_hold <= w_hs && r_tlast;
      case (r_dstate)
        DIDLE: begin
          if (w_dbg_req && !r_dbg_hold) begin
            r_dstate <= DARM;
            r_dlen   <= (config_reg_4_i == 32'd0) ? 32'd1 : config_reg_4_i;
          end
        end
        DARM: begin
          if (w_abort) begin
            r_dstate <= DIDLE;
          end else if (r_cfg_load) begin
            r_dstate <= DRUN;
            r_dcnt   <= '0;
            r_tvalid <= 1'b1;
            r_tlast  <= (r_dlen == 32'd1);
          end
        end
        DRUN: begin
          if (w_abort || (w_hs && r_tlast)) begin
            r_dstate <= DIDLE;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
          end else if (w_hs) begin
            r_dcnt  <= r_dcnt + 32'd1;
            r_tlast <= (r_dcnt + 32'd2 == r_dlen);
          end
        end
        default: begin
          r_dstate <= DIDLE;
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_o      = r_pulse;
  assign dds_enable_o = r_dds_en;
  assign cfg_load_o   = r_cfg_load;
  assign busy_o       = r_busy;
  assign pulse_cnt_o  = r_pulse_cnt;
  assign dbg_tvalid_o = r_tvalid;
  assign dbg_tlast_o  = r_tlast;

endmodule
